// File: rtl/bcd_lap_timer_if.sv
// rtl/bcd_lap_timer_if.sv - control/status bundle for the BCD lap timer
//
// Purpose: groups the buttons, preset value and count/flag outputs of
// bcd_lap_timer so the core and its user share one connection.
// Signals:
//   btn_ss     start/stop button level (pre-debounced, clk-synchronous)
//   btn_rl     load/clear/lap button level
//   up_down    1 = count up, 0 = count down
//   load_val   BCD preset, 4 bits per digit
//   q          current BCD count
//   running    high while counting
//   lap_q      last captured lap value
//   lap_valid  one-cycle pulse when lap_q updates
//   done       one-cycle pulse when a countdown hits zero
//   ovf        one-cycle pulse on up-count wrap to zero
// Modports: slave = timer core, master = controlling agent.
interface bcd_lap_timer_if #(
  parameter int unsigned NDIG = 4
);
  logic                  btn_ss;
  logic                  btn_rl;
  logic                  up_down;
  logic [4*NDIG-1:0]     load_val;
  logic [4*NDIG-1:0]     q;
  logic                  running;
  logic [4*NDIG-1:0]     lap_q;
  logic                  lap_valid;
  logic                  done;
  logic                  ovf;

  modport slave (
    input  btn_ss, btn_rl, up_down, load_val,
    output q, running, lap_q, lap_valid, done, ovf
  );

  modport master (
    output btn_ss, btn_rl, up_down, load_val,
    input  q, running, lap_q, lap_valid, done, ovf
  );
endinterface

// File: rtl/bcd_lap_timer.sv
// rtl/bcd_lap_timer.sv - NDIG-digit BCD up/down lap timer with prescaler
//
// Purpose: start/stop BCD timer with per-digit mod-6/mod-10 digits (mm:ss),
// a built-in tick prescaler, preset load/clear, lap capture, countdown done
// and up-count overflow flags.
// Ports:
//   clk           system clock, rising edge
//   master_reset  synchronous active-high reset
//   bus           bcd_lap_timer_if.slave (buttons, preset, count and flags)
module bcd_lap_timer #(
  parameter int unsigned     NDIG      = 4,
  parameter logic [NDIG-1:0] MOD6_MASK = NDIG'(4'b0010),
  parameter int unsigned     TICK_DIV  = 100000
) (
  input  logic             clk,
  input  logic             master_reset,
  bcd_lap_timer_if.slave   bus
);
  localparam int unsigned W  = 4 * NDIG;
  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic { ST_STOP, ST_RUN }    state_e;
  typedef enum logic { PH_LOAD, PH_CLEAR }  phase_e;

  state_e          state_q, state_d;
  phase_e          phase_q, phase_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [W-1:0]    cnt_q, cnt_d;
  logic [W-1:0]    lap_q, lap_d;
  logic            lap_valid_q, lap_valid_d;
  logic            done_q, done_d;
  logic            ovf_q, ovf_d;
  logic            ss_hist_q, rl_hist_q;

  logic            ss_e, rl_e, tick;
  logic [W-1:0]    inc_val, dec_val, clamp_val;
  logic            inc_carry, carry, borrow;

  function automatic logic [3:0] digit_max(input int i);
    return MOD6_MASK[i] ? 4'd5 : 4'd9;
  endfunction

  assign ss_e = bus.btn_ss & ~ss_hist_q;
  assign rl_e = bus.btn_rl & ~rl_hist_q;
  assign tick = (state_q == ST_RUN) && (presc_q == PW'(TICK_DIV - 1));

  // Ripple increment/decrement across digits; a full carry-out means wrap.
  always_comb begin
    inc_val   = cnt_q;
    dec_val   = cnt_q;
    clamp_val = '0;
    carry     = 1'b1;
    borrow    = 1'b1;
    for (int i = 0; i < int'(NDIG); i++) begin
      if (carry) begin
        if (cnt_q[4*i +: 4] >= digit_max(i)) begin
          inc_val[4*i +: 4] = 4'd0;
        end else begin
          inc_val[4*i +: 4] = cnt_q[4*i +: 4] + 4'd1;
          carry             = 1'b0;
        end
      end
      if (borrow) begin
        if (cnt_q[4*i +: 4] == 4'd0) begin
          dec_val[4*i +: 4] = digit_max(i);
        end else begin
          dec_val[4*i +: 4] = cnt_q[4*i +: 4] - 4'd1;
          borrow            = 1'b0;
        end
      end
      clamp_val[4*i +: 4] = (bus.load_val[4*i +: 4] > digit_max(i)) ?
                            digit_max(i) : bus.load_val[4*i +: 4];
    end
    inc_carry = carry;
  end

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    presc_d     = presc_q;
    cnt_d       = cnt_q;
    lap_d       = lap_q;
    lap_valid_d = 1'b0;
    done_d      = 1'b0;
    ovf_d       = 1'b0;
    if (state_q == ST_RUN) begin
      if (tick) begin
        presc_d = '0;
        if (bus.up_down) begin
          cnt_d = inc_val;
          ovf_d = inc_carry;
        end else if (cnt_q == '0) begin
          done_d  = 1'b1;
          state_d = ST_STOP;
        end else begin
          cnt_d = dec_val;
        end
      end else begin
        presc_d = presc_q + 1'b1;
      end
      // Lap captures the pre-tick count even when a step lands this cycle.
      if (rl_e && !ss_e) begin
        lap_d       = cnt_q;
        lap_valid_d = 1'b1;
      end
      if (ss_e) begin
        state_d = ST_STOP;
      end
    end else begin
      if (ss_e) begin
        state_d = ST_RUN;
        presc_d = '0;
      end else if (rl_e) begin
        if (phase_q == PH_LOAD) begin
          cnt_d   = clamp_val;
          phase_d = PH_CLEAR;
        end else begin
          cnt_d   = '0;
          phase_d = PH_LOAD;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (master_reset) begin
      state_q     <= ST_STOP;
      phase_q     <= PH_LOAD;
      presc_q     <= '0;
      cnt_q       <= '0;
      lap_q       <= '0;
      lap_valid_q <= 1'b0;
      done_q      <= 1'b0;
      ovf_q       <= 1'b0;
      ss_hist_q   <= 1'b0;
      rl_hist_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      presc_q     <= presc_d;
      cnt_q       <= cnt_d;
      lap_q       <= lap_d;
      lap_valid_q <= lap_valid_d;
      done_q      <= done_d;
      ovf_q       <= ovf_d;
      ss_hist_q   <= bus.btn_ss;
      rl_hist_q   <= bus.btn_rl;
    end
  end

  assign bus.q         = cnt_q;
  assign bus.running   = (state_q == ST_RUN);
  assign bus.lap_q     = lap_q;
  assign bus.lap_valid = lap_valid_q;
  assign bus.done      = done_q;
  assign bus.ovf       = ovf_q;
endmodule
